// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the RV64IM pipeline control unit and the
//   execute-stage mul/div unit: mul/div occupancy state encoding, default
//   occupancy latencies, and the load-use hazard match helper.
package pipe_ctrl_pkg;

  // Mul/div occupancy of the execute stage.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_HOLD = 2'd2
  } md_state_e;

  // Cycles a mul or div op occupies E when data memory is ready.
  localparam int MUL_LAT_DEF = 3;
  localparam int DIV_LAT_DEF = 34;

  // True when a load in some later stage writes a register the decode
  // instruction reads. x0 never creates a dependency.
  function automatic logic lu_match(
    input logic [4:0] rd,
    input logic       reg_wen,
    input logic       is_load,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    lu_match = is_load && reg_wen && (rd != 5'd0) &&
               ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// pipe_ctrl_perf_cnt
//   Saturating event counter used for the pipeline stall-cycle statistic.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset, clears the count
//   inc_i   count this cycle
//   cnt_o   current count, sticks at all-ones
module pipe_ctrl_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  output logic [PERF_W-1:0] cnt_o
);

  logic [PERF_W-1:0] cnt_d;
  logic [PERF_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {PERF_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline control for the 5-stage RV64IM core (F/D/E/M/W). Generates
//   per-stage stall/flush/bubble strobes for load-use hazards, E-stage
//   redirects, multi-cycle mul/div occupancy of E and data-memory wait,
//   and keeps a saturating count of fetch-stall cycles.
// Ports:
//   clk, rst                       clock, async active-low reset
//   decode_i_*                     source registers read by the D instruction
//   regE_i_*, regM_i_*             destination/load info of E and M instructions
//   execute_i_muldiv_valid/is_div  mul/div op present in E, and its kind
//   execute_i_redirect             taken branch/jump resolved in E
//   memory_i_stall                 data memory not ready
//   fetch_o_stall .. regW_o_bubble per-stage hold / NOP-insert strobes
//   muldiv_o_done                  one-cycle pulse, mul/div result valid
//   ctrl_o_stall_cycles            saturating count of fetch-stall cycles
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        decode_i_rs1,
  input  logic [4:0]        decode_i_rs2,
  input  logic              decode_i_use_rs1,
  input  logic              decode_i_use_rs2,
  input  logic [4:0]        regE_i_rd,
  input  logic              regE_i_reg_wen,
  input  logic              regE_i_is_load,
  input  logic [4:0]        regM_i_rd,
  input  logic              regM_i_reg_wen,
  input  logic              regM_i_is_load,
  input  logic              execute_i_muldiv_valid,
  input  logic              execute_i_is_div,
  input  logic              execute_i_redirect,
  input  logic              memory_i_stall,
  output logic              fetch_o_stall,
  output logic              regD_o_stall,
  output logic              regD_o_flush,
  output logic              regE_o_stall,
  output logic              regE_o_flush,
  output logic              regM_o_stall,
  output logic              regM_o_bubble,
  output logic              regW_o_bubble,
  output logic              muldiv_o_done,
  output logic [PERF_W-1:0] ctrl_o_stall_cycles
);

  // The first occupancy cycle is spent in RUN and the done cycle with
  // cnt==0, so the counter is loaded with LAT-2.
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);

  md_state_e        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             md_stall;
  logic             md_done;
  logic             lu_hazard;

  logic fetch_stall, d_stall, d_flush, e_stall, e_flush;
  logic m_stall, m_bubble, w_bubble, done;

  // ---------------------------------------------------------------------
  // Mul/div occupancy FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_done  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (execute_i_muldiv_valid) begin
          md_stall = 1'b1;
          state_d  = MD_BUSY;
          cnt_d    = execute_i_is_div ? DIV_INIT : MUL_INIT;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          // Keeps counting through memory stalls so the op finishes on time.
          md_stall = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end else if (!memory_i_stall) begin
          md_done = 1'b1;
          state_d = RUN;
        end else begin
          state_d = MD_HOLD;
        end
      end
      MD_HOLD: begin
        if (!memory_i_stall) begin
          md_done = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Hazard resolution and strobe generation
  // ---------------------------------------------------------------------
  always_comb begin
    lu_hazard = lu_match(regE_i_rd, regE_i_reg_wen, regE_i_is_load,
                         decode_i_rs1, decode_i_rs2,
                         decode_i_use_rs1, decode_i_use_rs2) ||
                lu_match(regM_i_rd, regM_i_reg_wen, regM_i_is_load,
                         decode_i_rs1, decode_i_rs2,
                         decode_i_use_rs1, decode_i_use_rs2);
  end

  always_comb begin
    fetch_stall = 1'b0;
    d_stall     = 1'b0;
    d_flush     = 1'b0;
    e_stall     = 1'b0;
    e_flush     = 1'b0;
    m_stall     = 1'b0;
    m_bubble    = 1'b0;
    w_bubble    = 1'b0;
    done        = 1'b0;
    if (memory_i_stall) begin
      // Whole-pipe freeze; M result cannot retire, so W gets a NOP.
      fetch_stall = 1'b1;
      d_stall     = 1'b1;
      e_stall     = 1'b1;
      m_stall     = 1'b1;
      w_bubble    = 1'b1;
    end else begin
      done = md_done;
      if (md_stall) begin
        fetch_stall = 1'b1;
        d_stall     = 1'b1;
        e_stall     = 1'b1;
        m_bubble    = 1'b1;
      end else if ((state_q == RUN) && !execute_i_muldiv_valid) begin
        if (execute_i_redirect) begin
          // Fetch runs free so the redirect target is taken this edge.
          d_flush = 1'b1;
          e_flush = 1'b1;
        end else if (lu_hazard) begin
          fetch_stall = 1'b1;
          d_stall     = 1'b1;
          e_flush     = 1'b1;
        end
      end
    end
  end

  // Strobes read zero throughout reset, independent of the inputs.
  assign fetch_o_stall = rst & fetch_stall;
  assign regD_o_stall  = rst & d_stall;
  assign regD_o_flush  = rst & d_flush;
  assign regE_o_stall  = rst & e_stall;
  assign regE_o_flush  = rst & e_flush;
  assign regM_o_stall  = rst & m_stall;
  assign regM_o_bubble = rst & m_bubble;
  assign regW_o_bubble = rst & w_bubble;
  assign muldiv_o_done = rst & done;

  pipe_ctrl_perf_cnt #(
    .PERF_W(PERF_W)
  ) u_perf_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(fetch_o_stall),
    .cnt_o(ctrl_o_stall_cycles)
  );

endmodule
